// File: rtl/sdram_read_checker.sv
// sdram_read_checker: Avalon-MM read master that streams a buffer back from SDRAM
// and checks each word against {~k, k}. Define SDRAM_RD_CHK_FIRST_ERR_EN to capture the first failing index.
module sdram_read_checker #(
    parameter int ADDR_W          = 28,
    parameter int DATA_W          = 128,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_stb_i,
    input  logic [31:0]       base_addr_i,
    input  logic [31:0]       word_cnt_i,
    output logic              busy_o,
    output logic              done_stb_o,
    output logic [31:0]       err_cnt_o,
    output logic [31:0]       first_err_idx_o,
    output logic [31:0]       cycle_cnt_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic [7:0]        avm_burstcount_o,
    output logic              avm_read_o,
    input  logic              avm_waitrequest_i,
    input  logic [DATA_W-1:0] avm_readdata_i,
    input  logic              avm_readdatavalid_i
);

    localparam int HALF_W = DATA_W / 2;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] expected_word(input logic [63:0] k);
        logic [HALF_W-1:0] lo;
        lo = HALF_W'(k);
        return {~lo, lo};
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       issued_q, issued_d;
    logic [31:0]       rcvd_q, rcvd_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [63:0]       k_q, k_d;
    logic [31:0]       err_q, err_d;
    logic [31:0]       cyc_q, cyc_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic start_s;
    logic accept_s;
    logic rsp_s;
    logic mismatch_s;
    logic unused_s;

    assign start_s    = start_stb_i && (state_q == ST_IDLE);
    assign accept_s   = read_q && !avm_waitrequest_i;
    // Responses with nothing outstanding (e.g. leftovers from before a reset) are dropped.
    assign rsp_s      = avm_readdatavalid_i && (out_q != {OUT_W{1'b0}});
    assign mismatch_s = rsp_s && (avm_readdata_i != expected_word(k_q));
    assign unused_s   = ^{addr_q, k_q};

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_stb_i) begin
                    state_d = (word_cnt_i != 32'd0) ? ST_ISSUE : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s && ((issued_q + 32'd1) == cnt_q)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (rsp_s && ((rcvd_q + 32'd1) == cnt_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters and checker datapath next values.
    always_comb begin
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        rcvd_d   = rcvd_q;
        out_d    = out_q;
        k_d      = k_q;
        err_d    = err_q;
        cyc_d    = cyc_q;
        if (start_s) begin
            addr_d   = base_addr_i;
            cnt_d    = word_cnt_i;
            issued_d = 32'd0;
            rcvd_d   = 32'd0;
            out_d    = {OUT_W{1'b0}};
            k_d      = 64'd0;
            err_d    = 32'd0;
            cyc_d    = 32'd0;
        end else begin
            addr_d   = accept_s ? (addr_q + 32'd1) : addr_q;
            issued_d = issued_q + {31'd0, accept_s};
            rcvd_d   = rcvd_q + {31'd0, rsp_s};
            k_d      = k_q + {63'd0, rsp_s};
            cyc_d    = cyc_q + {31'd0, busy_q};
            case ({accept_s, rsp_s})
                2'b10:   out_d = out_q + OUT_ONE;
                2'b01:   out_d = out_q - OUT_ONE;
                default: out_d = out_q;
            endcase
            if (mismatch_s && (err_q != 32'hFFFF_FFFF)) begin
                err_d = err_q + 32'd1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q   <= 32'd0;
            cnt_q    <= 32'd0;
            issued_q <= 32'd0;
            rcvd_q   <= 32'd0;
            out_q    <= {OUT_W{1'b0}};
            k_q      <= 64'd0;
            err_q    <= 32'd0;
            cyc_q    <= 32'd0;
        end else begin
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            rcvd_q   <= rcvd_d;
            out_q    <= out_d;
            k_q      <= k_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
        end
    end

    // Output decode from the next state, so the request and strobes are registered.
    always_comb begin
        read_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_ISSUE: begin
                busy_d = 1'b1;
                read_d = (issued_d < cnt_d) && (out_d < OUT_MAX);
            end
            ST_DRAIN: busy_d = 1'b1;
            ST_DONE:  done_d = 1'b1;
            default: begin
                read_d = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            read_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            read_q <= read_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
    logic [31:0] first_err_q, first_err_d;
    logic        first_seen_q, first_seen_d;

    // Capture k of the first mismatch; held until the next accepted start.
    always_comb begin
        first_err_d  = first_err_q;
        first_seen_d = first_seen_q;
        if (start_s) begin
            first_err_d  = 32'hFFFF_FFFF;
            first_seen_d = 1'b0;
        end else if (mismatch_s && !first_seen_q) begin
            first_err_d  = k_q[31:0];
            first_seen_d = 1'b1;
        end else begin
            first_err_d  = first_err_q;
            first_seen_d = first_seen_q;
        end
    end

    // First-error capture registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            first_err_q  <= 32'hFFFF_FFFF;
            first_seen_q <= 1'b0;
        end else begin
            first_err_q  <= first_err_d;
            first_seen_q <= first_seen_d;
        end
    end

    assign first_err_idx_o = first_err_q;
`else
    assign first_err_idx_o = 32'hFFFF_FFFF;
`endif

    assign busy_o           = busy_q;
    assign done_stb_o       = done_q;
    assign err_cnt_o        = err_q;
    assign cycle_cnt_o      = cyc_q;
    assign avm_address_o    = addr_q[ADDR_W-1:0];
    assign avm_burstcount_o = 8'd1;
    assign avm_read_o       = read_q;

endmodule

// File: tb/tb_sdram_read_checker.sv
// Directed bench for sdram_read_checker: table of check runs against a latency-configurable
// slave model, plus hand sequences for reset-time behaviour and mid-run reset.
`timescale 1ns/1ps
module tb_sdram_read_checker;

    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 128;
    localparam int MAX_OUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_stb;
    logic [31:0]       base_addr;
    logic [31:0]       word_cnt;
    logic              busy;
    logic              done_stb;
    logic [31:0]       err_cnt;
    logic [31:0]       first_err;
    logic [31:0]       cycle_cnt;
    logic [ADDR_W-1:0] avm_address;
    logic [7:0]        avm_burstcount;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    always #5 clk = ~clk;

    sdram_read_checker #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .start_stb_i(start_stb),
        .base_addr_i(base_addr),
        .word_cnt_i(word_cnt),
        .busy_o(busy),
        .done_stb_o(done_stb),
        .err_cnt_o(err_cnt),
        .first_err_idx_o(first_err),
        .cycle_cnt_o(cycle_cnt),
        .avm_address_o(avm_address),
        .avm_burstcount_o(avm_burstcount),
        .avm_read_o(avm_read),
        .avm_waitrequest_i(avm_waitrequest),
        .avm_readdata_i(avm_readdata),
        .avm_readdatavalid_i(avm_readdatavalid)
    );

    typedef struct {
        logic [31:0] base;
        logic [31:0] cnt;
        int          lat;
        bit          rnd;
        int          corrupt;
        int          restrike;
        logic [31:0] exp_err;
        bit          chk_timing;
        int          exp_cycle;
        int          exp_lat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt, done_cnt, done_cyc, rsp_k, out_tb, max_out;
    int unsigned addr_bad, hold_bad, busy_seen;
    logic [31:0] err_at_done;
    int          lat;
    bit          rnd_wait;
    int          corrupt_k;
    logic [31:0] run_base;
    int unsigned due_q[$];
    bit          prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    vec_t        vecs[7];

    function automatic logic [DATA_W-1:0] pattern(input logic [63:0] k);
        return {~k, k};
    endfunction

    function automatic logic [31:0] exp_first(input int corrupt);
`ifdef SDRAM_RD_CHK_FIRST_ERR_EN
        return (corrupt < 0) ? 32'hFFFF_FFFF : 32'(corrupt);
`else
        return 32'hFFFF_FFFF;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_run();
        acc_cnt = 0; done_cnt = 0; done_cyc = 0; rsp_k = 0; out_tb = 0; max_out = 0;
        addr_bad = 0; hold_bad = 0; busy_seen = 0; err_at_done = 32'hDEAD_BEEF;
        prev_stall = 1'b0; prev_addr = '0;
        due_q.delete();
    endtask

    // One clock of the slave model, acting on the falling edge.
    task automatic slave_step();
        int unsigned d;
        @(negedge clk);
        cyc++;
        if (done_stb) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = err_cnt;
        end
        if (busy) busy_seen++;
        if (prev_stall && !(avm_read && (avm_address == prev_addr))) hold_bad++;
        if ((due_q.size() > 0) && (due_q[0] == cyc)) begin
            d = due_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = (int'(rsp_k) == corrupt_k) ? '0 : pattern(64'(rsp_k));
            rsp_k++;
            out_tb--;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
        end
        avm_waitrequest = rnd_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (avm_read && !avm_waitrequest) begin
            if (avm_address != ADDR_W'(run_base + acc_cnt)) addr_bad++;
            acc_cnt++;
            due_q.push_back(cyc + int'(lat));
            out_tb++;
        end
        if (out_tb > max_out) max_out = out_tb;
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
    endtask

    task automatic run_check(input vec_t v, output int done_lat);
        int unsigned start_cyc;
        int n;
        clear_run();
        run_base = v.base; lat = v.lat; rnd_wait = v.rnd; corrupt_k = v.corrupt;
        slave_step();
        start_stb = 1'b1; base_addr = v.base; word_cnt = v.cnt;
        start_cyc = cyc;
        slave_step();
        start_stb = 1'b0; base_addr = 32'h0999_0000; word_cnt = 32'd7;
        n = 0;
        while ((done_cnt == 0) && (n < 3000)) begin
            slave_step();
            n++;
            if ((v.restrike > 0) && (cyc == start_cyc + v.restrike)) begin
                start_stb = 1'b1; base_addr = 32'h0000_0999; word_cnt = 32'd2;
            end else begin
                start_stb = 1'b0;
            end
        end
        repeat (4) slave_step();
        done_lat = int'(done_cyc) - int'(start_cyc);
    endtask

    initial begin
        int dl;
        int n;
        int unsigned acc_before;
        rst_n = 1'b0; start_stb = 1'b0; base_addr = '0; word_cnt = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        clear_run();
        lat = 3; rnd_wait = 1'b0; corrupt_k = -1; run_base = '0;

        //                 base           cnt    lat rnd corr rstk err   tmg cyc lat
        vecs[0] = '{32'h0000_0100, 32'd16, 3,  0, -1,  0,  32'd0, 1,  19, 20};
        vecs[1] = '{32'h0000_2000, 32'd8,  3,  0,  5,  0,  32'd1, 1,  11, 12};
        vecs[2] = '{32'h0000_0040, 32'd32, 10, 1, -1,  0,  32'd0, 0,  0,  0};
        vecs[3] = '{32'hFFFF_FFFE, 32'd4,  1,  0, -1,  0,  32'd0, 1,  5,  6};
        vecs[4] = '{32'h0000_0000, 32'd3,  4,  0,  0,  0,  32'd1, 1,  7,  8};
        vecs[5] = '{32'h0000_0300, 32'd16, 3,  0, -1,  5,  32'd0, 1,  19, 20};
        vecs[6] = '{32'h0000_0500, 32'd0,  3,  0, -1,  0,  32'd0, 1,  0,  1};

        repeat (3) @(negedge clk);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_done",   64'(done_stb), 64'd0);
        check("rst_read",   64'(avm_read), 64'd0);
        check("rst_addr",   64'(avm_address), 64'd0);
        check("rst_err",    64'(err_cnt), 64'd0);
        check("rst_cycle",  64'(cycle_cnt), 64'd0);
        check("rst_first",  64'(first_err), 64'hFFFF_FFFF);
        check("burstcount", 64'(avm_burstcount), 64'd1);
        rst_n = 1'b1;

        // Reset while 4 of 16 reads are accepted, then stray responses.
        clear_run();
        run_base = 32'h0000_0500; lat = 3; rnd_wait = 1'b0; corrupt_k = -1;
        slave_step();
        start_stb = 1'b1; base_addr = 32'h0000_0500; word_cnt = 32'd16;
        slave_step();
        start_stb = 1'b0;
        n = 0;
        while ((acc_cnt < 4) && (n < 100)) begin
            slave_step();
            n++;
        end
        check("mid_accepts", 64'(acc_cnt), 64'd4);
        acc_before = acc_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_read", 64'(avm_read), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_addr", 64'(avm_address), 64'd0);
        due_q.delete();
        avm_readdatavalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_stb) done_cnt++;
            if (avm_read) acc_cnt++;
            avm_readdatavalid = 1'b1;
            avm_readdata      = '0;
        end
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        repeat (4) slave_step();
        check("stray_no_reads", 64'(acc_cnt), 64'(acc_before));
        check("stray_no_done",  64'(done_cnt), 64'd0);
        check("stray_err",      64'(err_cnt), 64'd0);
        check("stray_busy",     64'(busy), 64'd0);
        check("stray_cycle",    64'(cycle_cnt), 64'd0);
        check("stray_first",    64'(first_err), 64'hFFFF_FFFF);
        check("stray_addr",     64'(avm_address), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_check(vecs[i], dl);
            check($sformatf("v%0d_done_count", i), 64'(done_cnt), 64'd1);
            check($sformatf("v%0d_reads", i), 64'(acc_cnt), 64'(vecs[i].cnt));
            check($sformatf("v%0d_rsps", i), 64'(rsp_k), 64'(vecs[i].cnt));
            check($sformatf("v%0d_addr_seq", i), 64'(addr_bad), 64'd0);
            check($sformatf("v%0d_addr_hold", i), 64'(hold_bad), 64'd0);
            check($sformatf("v%0d_max_out_le4", i), 64'(max_out <= MAX_OUT), 64'd1);
            check($sformatf("v%0d_err_at_done", i), 64'(err_at_done), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_first_err", i), 64'(first_err), 64'(exp_first(vecs[i].corrupt)));
            if (vecs[i].chk_timing) begin
                check($sformatf("v%0d_cycle_cnt", i), 64'(cycle_cnt), 64'(vecs[i].exp_cycle));
                check($sformatf("v%0d_busy_cycles", i), 64'(busy_seen), 64'(vecs[i].exp_cycle));
                check($sformatf("v%0d_done_latency", i), 64'(dl), 64'(vecs[i].exp_lat));
            end
        end
        check("rnd_run_max_out_hit", 64'(vecs[2].lat > MAX_OUT), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
